// File: rtl/x_down_counter_16_bit.sv
// Loadable 16-bit down counter / interval timer with a registered terminal-count pulse.
// Define X_DOWN_COUNTER_16_BIT_RELOAD_EN to auto-reload on terminal count (periodic timer).
module x_down_counter_16_bit (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_load_15,
  input  logic i_load_14,
  input  logic i_load_13,
  input  logic i_load_12,
  input  logic i_load_11,
  input  logic i_load_10,
  input  logic i_load_9,
  input  logic i_load_8,
  input  logic i_load_7,
  input  logic i_load_6,
  input  logic i_load_5,
  input  logic i_load_4,
  input  logic i_load_3,
  input  logic i_load_2,
  input  logic i_load_1,
  input  logic i_load_0,
  output logic o_count_15,
  output logic o_count_14,
  output logic o_count_13,
  output logic o_count_12,
  output logic o_count_11,
  output logic o_count_10,
  output logic o_count_9,
  output logic o_count_8,
  output logic o_count_7,
  output logic o_count_6,
  output logic o_count_5,
  output logic o_count_4,
  output logic o_count_3,
  output logic o_count_2,
  output logic o_count_1,
  output logic o_count_0,
  output logic o_zero,
  output logic o_tc
);

  localparam int unsigned CountW = 16;

  logic [CountW-1:0] load_val;
  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;
  logic              tc_q;
  logic              tc_d;
  logic [CountW-1:0] term_val;

  // Flattened pins regrouped into a bus, bit 15 is the MSB.
  assign load_val = {i_load_15, i_load_14, i_load_13, i_load_12,
                     i_load_11, i_load_10, i_load_9,  i_load_8,
                     i_load_7,  i_load_6,  i_load_5,  i_load_4,
                     i_load_3,  i_load_2,  i_load_1,  i_load_0};

  assign {o_count_15, o_count_14, o_count_13, o_count_12,
          o_count_11, o_count_10, o_count_9,  o_count_8,
          o_count_7,  o_count_6,  o_count_5,  o_count_4,
          o_count_3,  o_count_2,  o_count_1,  o_count_0} = count_q;

  assign o_zero = (count_q == CountW'(0));
  assign o_tc   = tc_q;

`ifdef X_DOWN_COUNTER_16_BIT_RELOAD_EN
  logic [CountW-1:0] reload_q;
  logic [CountW-1:0] reload_d;

  // Reload value captured on every load; the terminal step returns to it.
  always_comb begin
    reload_d = reload_q;
    if (i_load) begin
      reload_d = load_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  assign term_val = reload_q;
`else
  assign term_val = '0;
`endif

  // Priority: load, then enabled decrement / terminal step; count never wraps below 0.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (i_load) begin
      count_d = load_val;
    end else if (i_en) begin
      if (count_q > CountW'(1)) begin
        count_d = count_q - CountW'(1);
      end else if (count_q == CountW'(1)) begin
        count_d = term_val;
        tc_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

endmodule

// File: tb/tb_x_down_counter_16_bit.sv
// Scoreboard bench for x_down_counter_16_bit: driver queues hand-computed expectations,
// monitor pops one per rising edge (or per async-reset probe) and compares.
module tb_x_down_counter_16_bit;

  typedef struct {
    logic [15:0] cnt;
    logic        zero;
    logic        tc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        en;
  logic [15:0] lval;
  logic [15:0] dut_cnt;
  logic        dut_zero;
  logic        dut_tc;

  exp_t exp_q[$];
  event chk_ev;
  int   checks;
  int   errors;

  x_down_counter_16_bit dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (load),
    .i_en      (en),
    .i_load_15 (lval[15]),
    .i_load_14 (lval[14]),
    .i_load_13 (lval[13]),
    .i_load_12 (lval[12]),
    .i_load_11 (lval[11]),
    .i_load_10 (lval[10]),
    .i_load_9  (lval[9]),
    .i_load_8  (lval[8]),
    .i_load_7  (lval[7]),
    .i_load_6  (lval[6]),
    .i_load_5  (lval[5]),
    .i_load_4  (lval[4]),
    .i_load_3  (lval[3]),
    .i_load_2  (lval[2]),
    .i_load_1  (lval[1]),
    .i_load_0  (lval[0]),
    .o_count_15(dut_cnt[15]),
    .o_count_14(dut_cnt[14]),
    .o_count_13(dut_cnt[13]),
    .o_count_12(dut_cnt[12]),
    .o_count_11(dut_cnt[11]),
    .o_count_10(dut_cnt[10]),
    .o_count_9 (dut_cnt[9]),
    .o_count_8 (dut_cnt[8]),
    .o_count_7 (dut_cnt[7]),
    .o_count_6 (dut_cnt[6]),
    .o_count_5 (dut_cnt[5]),
    .o_count_4 (dut_cnt[4]),
    .o_count_3 (dut_cnt[3]),
    .o_count_2 (dut_cnt[2]),
    .o_count_1 (dut_cnt[1]),
    .o_count_0 (dut_cnt[0]),
    .o_zero    (dut_zero),
    .o_tc      (dut_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string name, input logic [15:0] c, input logic tc);
    exp_t e;
    e.cnt  = c;
    e.zero = (c == 16'h0000);
    e.tc   = tc;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge; expectation is the state after the next rise.
  task automatic step(input string name, input logic ld, input logic [15:0] v, input logic e,
                      input logic [15:0] exp_c, input logic exp_tc);
    @(negedge clk);
    load = ld;
    lval = v;
    en   = e;
    push_exp(name, exp_c, exp_tc);
  endtask

  // Assert reset between edges, probe immediately, hold for n cycles, release.
  task automatic reset_pulse(input string name, input logic e, input int n);
    @(negedge clk);
    load = 1'b0;
    en   = e;
    #2;
    rst_n = 1'b0;
    push_exp({name, "_async"}, 16'h0000, 1'b0);
    -> chk_ev;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_exp({name, "_held"}, 16'h0000, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp({name, "_rel"}, 16'h0000, 1'b0);
  endtask

  // Monitor: every rising edge (or async probe) the outputs are compared against the queue head.
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (dut_cnt !== e.cnt || dut_zero !== e.zero || dut_tc !== e.tc) begin
          errors++;
          $display("FAIL %s: got count=%h zero=%b tc=%b, expected count=%h zero=%b tc=%b",
                   e.name, dut_cnt, dut_zero, dut_tc, e.cnt, e.zero, e.tc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
    lval   = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step("reset_idle", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Async reset from a loaded value
    step("load_1234", 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0);
    reset_pulse("rst_1234", 1'b0, 1);
    step("post_rst_idle", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);

    // Countdown from 3
    step("load_3", 1'b1, 16'h0003, 1'b0, 16'h0003, 1'b0);
    step("dec_2", 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0);
    step("dec_1", 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0);
`ifdef X_DOWN_COUNTER_16_BIT_RELOAD_EN
    step("term_reload3", 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1);
    step("dec_2b", 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0);
`else
    step("term_0", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) step("hold_0", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
`endif

    // Periodic: 4,3,2,1,4... or one-shot equivalent
    step("load_4", 1'b1, 16'h0004, 1'b0, 16'h0004, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("per_3", 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0);
      step("per_2", 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0);
      step("per_1", 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0);
`ifdef X_DOWN_COUNTER_16_BIT_RELOAD_EN
      step("per_term4", 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1);
`else
      step("per_term0", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
      step("per_reload4", 1'b1, 16'h0004, 1'b0, 16'h0004, 1'b0);
`endif
    end

    // Load beats terminal step
    step("load_1", 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0);
    step("load_prio_beef", 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0);

    // Enable gating
    step("load_0100", 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b0);
    for (int i = 0; i < 3; i++) step("gate_hold", 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b0);

    // Top of range
    step("load_ffff", 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0);
    step("dec_fffe", 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0);

    // Load zero never pulses
    step("load_0", 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) step("zero_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);

    // Load 1 with enable held
    step("load_1_en", 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b0);
`ifdef X_DOWN_COUNTER_16_BIT_RELOAD_EN
    for (int i = 0; i < 3; i++) step("tc_every", 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1);
`else
    step("tc_once", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
    step("tc_done", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
`endif

    // Reset mid-count, then stays idle at 0
    step("load_2", 1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0);
    reset_pulse("rst_mid", 1'b1, 2);
    for (int i = 0; i < 3; i++) step("post_mid_idle", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    step("reload_after_rst", 1'b1, 16'h0005, 1'b1, 16'h0005, 1'b0);
    step("dec_4", 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0);

    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
